// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//   Shares one combinational ALU between two requesters. Only one operation
//   is in flight at a time: it is accepted, then executed for one cycle on the
//   ALU, then held as a registered response until the consumer takes it.
//
// Parameters
//   FIXED_PRIORITY : 1 = requester 0 always wins contention, 0 = round-robin.
//
// Ports
//   clk, resetn               : clock, synchronous active-low reset
//   reqK_valid / reqK_ready   : requester K handshake (K = 0, 1)
//   reqK_op_a/op_b/funct3/op_sign : operation of requester K
//   alu_execute, alu_op_a/op_b/funct3/op_sign : drive to the shared ALU
//   alu_result, alu_zero/negative/overflow    : results from the shared ALU
//   rsp_valid / rsp_ready     : response handshake
//   rsp_id, rsp_result, rsp_zero/negative/overflow : registered response
//   dbg_state_o               : current FSM state (IDLE=0, EXEC=1, RESP=2)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. reqK_ready is a combinational function of the valids and the
// FSM state; valid may drop before ready, in which case nothing is captured.
// rsp_* stay stable while rsp_valid is high and rsp_ready is low.
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_op_a,
    input  logic [31:0] req0_op_b,
    input  logic [2:0]  req0_funct3,
    input  logic        req0_op_sign,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_op_a,
    input  logic [31:0] req1_op_b,
    input  logic [2:0]  req1_funct3,
    input  logic        req1_op_sign,

    output logic        alu_execute,
    output logic [31:0] alu_op_a,
    output logic [31:0] alu_op_b,
    output logic [2:0]  alu_funct3,
    output logic        alu_op_sign,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_negative,
    input  logic        alu_overflow,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_negative,
    output logic        rsp_overflow,

    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        last_grant_q;
    logic [31:0] op_a_q, op_b_q;
    logic [2:0]  funct3_q;
    logic        op_sign_q;
    logic        id_q;

    logic        accept_win;
    logic        sel;
    logic        grant;

    // Grant selection and next-state logic.
    always_comb begin
        accept_win = 1'b0;
        sel        = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        grant      = 1'b0;
        state_d    = state_q;

        // A new operation may only enter when the slot is empty or is being
        // emptied this very cycle.
        accept_win = resetn &&
                     ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));

        if (req0_valid && req1_valid) begin
            sel = FIXED_PRIORITY ? 1'b0 : ~last_grant_q;
        end else begin
            sel = req1_valid;
        end

        req0_ready = accept_win && req0_valid && !sel;
        req1_ready = accept_win && req1_valid &&  sel;
        grant      = req0_ready || req1_ready;

        case (state_q)
            IDLE:    if (grant) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP: begin
                if (rsp_ready) state_d = grant ? EXEC : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            op_a_q       <= '0;
            op_b_q       <= '0;
            funct3_q     <= '0;
            op_sign_q    <= 1'b0;
            id_q         <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_result   <= '0;
            rsp_zero     <= 1'b0;
            rsp_negative <= 1'b0;
            rsp_overflow <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                last_grant_q <= sel;
                id_q         <= sel;
                op_a_q       <= sel ? req1_op_a    : req0_op_a;
                op_b_q       <= sel ? req1_op_b    : req0_op_b;
                funct3_q     <= sel ? req1_funct3  : req0_funct3;
                op_sign_q    <= sel ? req1_op_sign : req0_op_sign;
            end
            if (state_q == EXEC) begin
                rsp_id       <= id_q;
                rsp_result   <= alu_result;
                rsp_zero     <= alu_zero;
                rsp_negative <= alu_negative;
                rsp_overflow <= alu_overflow;
            end
        end
    end

    // The ALU buses always show the captured operation, so they hold their
    // last value outside EXEC; only the enable is qualified.
    assign alu_execute = resetn && (state_q == EXEC);
    assign alu_op_a    = op_a_q;
    assign alu_op_b    = op_b_q;
    assign alu_funct3  = funct3_q;
    assign alu_op_sign = op_sign_q;

    assign rsp_valid   = (state_q == RESP);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//   Bench for alu_arbiter. Two instances: round-robin (main) and fixed
//   priority. A small RV32I ALU model closes the loop on each instance's ALU
//   port. Expected responses are pushed to exp_q when an operation is granted
//   and popped by a monitor at each response handshake.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    // ---------------- round-robin instance signals ----------------
    logic        rv [2];
    logic        rr [2];
    logic [31:0] ra [2];
    logic [31:0] rb [2];
    logic [2:0]  rf [2];
    logic        rs [2];
    logic        rsp_ready;

    logic        alu_execute, alu_op_sign, alu_zero, alu_negative, alu_overflow;
    logic [31:0] alu_op_a, alu_op_b, alu_result;
    logic [2:0]  alu_funct3;
    logic        rsp_valid, rsp_id, rsp_zero, rsp_negative, rsp_overflow;
    logic [31:0] rsp_result;
    logic [1:0]  dbg_state;

    // ---------------- fixed-priority instance signals ----------------
    logic        f_v0, f_v1, f_r0, f_r1, f_rsp_ready;
    logic        f_exec, f_sign, f_zero, f_neg, f_ovf;
    logic [31:0] f_op_a, f_op_b, f_res;
    logic [2:0]  f_f3;
    logic        f_rsp_valid, f_rsp_id, f_rsp_zero, f_rsp_neg, f_rsp_ovf;
    logic [31:0] f_rsp_result;
    logic [1:0]  f_dbg_state;

    // Reference ALU: returns {overflow, negative, zero, result}.
    function automatic logic [34:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f, input logic s);
        logic [31:0] r;
        logic        v;
        v = 1'b0;
        case (f)
            3'b000: begin
                r = s ? (a - b) : (a + b);
                if (s) v = (a[31] != b[31]) && (r[31] != a[31]);
                else   v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'b001: r = a << b[4:0];
            3'b010: r = {31'b0, $signed(a) < $signed(b)};
            3'b011: r = {31'b0, a < b};
            3'b100: r = a ^ b;
            3'b101: r = s ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            3'b110: r = a | b;
            default: r = a & b;
        endcase
        return {v, r[31], (r == 32'd0), r};
    endfunction

    assign {alu_overflow, alu_negative, alu_zero, alu_result} =
        alu_f(alu_op_a, alu_op_b, alu_funct3, alu_op_sign);
    assign {f_ovf, f_neg, f_zero, f_res} = alu_f(f_op_a, f_op_b, f_f3, f_sign);

    alu_arbiter #(.FIXED_PRIORITY(1'b0)) dut (
        .clk(clk), .resetn(resetn),
        .req0_valid(rv[0]), .req0_ready(rr[0]), .req0_op_a(ra[0]), .req0_op_b(rb[0]),
        .req0_funct3(rf[0]), .req0_op_sign(rs[0]),
        .req1_valid(rv[1]), .req1_ready(rr[1]), .req1_op_a(ra[1]), .req1_op_b(rb[1]),
        .req1_funct3(rf[1]), .req1_op_sign(rs[1]),
        .alu_execute(alu_execute), .alu_op_a(alu_op_a), .alu_op_b(alu_op_b),
        .alu_funct3(alu_funct3), .alu_op_sign(alu_op_sign), .alu_result(alu_result),
        .alu_zero(alu_zero), .alu_negative(alu_negative), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_negative(rsp_negative),
        .rsp_overflow(rsp_overflow), .dbg_state_o(dbg_state)
    );

    alu_arbiter #(.FIXED_PRIORITY(1'b1)) dut_fp (
        .clk(clk), .resetn(resetn),
        .req0_valid(f_v0), .req0_ready(f_r0), .req0_op_a(32'd1), .req0_op_b(32'd2),
        .req0_funct3(3'b000), .req0_op_sign(1'b0),
        .req1_valid(f_v1), .req1_ready(f_r1), .req1_op_a(32'd5), .req1_op_b(32'd5),
        .req1_funct3(3'b000), .req1_op_sign(1'b0),
        .alu_execute(f_exec), .alu_op_a(f_op_a), .alu_op_b(f_op_b),
        .alu_funct3(f_f3), .alu_op_sign(f_sign), .alu_result(f_res),
        .alu_zero(f_zero), .alu_negative(f_neg), .alu_overflow(f_ovf),
        .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready), .rsp_id(f_rsp_id),
        .rsp_result(f_rsp_result), .rsp_zero(f_rsp_zero), .rsp_negative(f_rsp_neg),
        .rsp_overflow(f_rsp_ovf), .dbg_state_o(f_dbg_state)
    );

    // ---------------- scoreboard ----------------
    // Expected word: {id, zero, negative, overflow, result}
    logic [35:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Response monitor: inputs change at negedge, so +2 is stable up to the
    // following rising edge where the handshake completes.
    always @(negedge clk) begin
        #2;
        if (resetn && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
            end else begin
                chk("rsp", 64'({rsp_id, rsp_zero, rsp_negative, rsp_overflow, rsp_result}),
                    64'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
        chk("drain", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        tick();
    endtask

    // Raise valid for requester id and wait (bounded) for its ready.
    task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f3, input logic s, input logic push,
                         input logic [35:0] exp);
        bit got;
        got = 1'b0;
        rv[id] = 1'b1; ra[id] = a; rb[id] = b; rf[id] = f3; rs[id] = s;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (rr[id]) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("grant", 64'(got), 64'd1);
        if (got && push) exp_q.push_back(exp);
    endtask

    // Accept at N, alu_execute at N+1, rsp_valid at N+2 (rsp_ready held high).
    task automatic lat_test(input int id, input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] f3, input logic s, input logic [35:0] exp);
        issue(id, a, b, f3, s, 1'b1, exp);
        chk("lat_exec_at_n", 64'(alu_execute), 64'd0);
        tick();
        rv[id] = 1'b0;
        #1;
        chk("lat_exec_at_n1", 64'(alu_execute), 64'd1);
        chk("lat_bus_a", 64'(alu_op_a), 64'(a));
        chk("lat_bus_b", 64'(alu_op_b), 64'(b));
        chk("lat_bus_f3s", 64'({alu_funct3, alu_op_sign}), 64'({f3, s}));
        chk("lat_rsp_at_n1", 64'(rsp_valid), 64'd0);
        tick();
        #1;
        chk("lat_rsp_at_n2", 64'(rsp_valid), 64'd1);
        chk("lat_exec_off", 64'(alu_execute), 64'd0);
        chk("lat_bus_hold", 64'(alu_op_a), 64'(a));
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic        s;
        logic [31:0] a, b, r;
        logic        z, n, v;
    } vec_t;

    vec_t vt [11];
    int   fp_cnt;
    bit   fp_r1_seen;

    initial begin
        // Hand-computed vectors: funct3, sign, a, b, result, z, n, v
        vt[0]  = '{3'b000, 1'b0, 32'd12,         32'd13,         32'h0000_0019, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{3'b000, 1'b1, 32'd11,         32'd13,         32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0};
        vt[2]  = '{3'b000, 1'b0, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000, 1'b0, 1'b1, 1'b1};
        vt[3]  = '{3'b000, 1'b1, 32'd5,          32'd5,          32'h0000_0000, 1'b1, 1'b0, 1'b0};
        vt[4]  = '{3'b100, 1'b0, 32'hF0F0_F0F0,  32'hFFFF_0000,  32'h0F0F_F0F0, 1'b0, 1'b0, 1'b0};
        vt[5]  = '{3'b111, 1'b0, 32'hFF00_FF00,  32'h0F0F_0F0F,  32'h0F00_0F00, 1'b0, 1'b0, 1'b0};
        vt[6]  = '{3'b110, 1'b0, 32'h0000_0001,  32'h8000_0000,  32'h8000_0001, 1'b0, 1'b1, 1'b0};
        vt[7]  = '{3'b001, 1'b0, 32'h0000_0001,  32'd31,         32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vt[8]  = '{3'b101, 1'b1, 32'h8000_0000,  32'd4,          32'hF800_0000, 1'b0, 1'b1, 1'b0};
        vt[9]  = '{3'b101, 1'b0, 32'h8000_0000,  32'd4,          32'h0800_0000, 1'b0, 1'b0, 1'b0};
        vt[10] = '{3'b011, 1'b0, 32'hFFFF_FFFF,  32'd1,          32'h0000_0000, 1'b1, 1'b0, 1'b0};

        for (int i = 0; i < 2; i++) begin
            rv[i] = 1'b1; ra[i] = 32'd0; rb[i] = 32'd0; rf[i] = 3'd0; rs[i] = 1'b0;
        end
        rsp_ready = 1'b1;
        f_v0 = 1'b1; f_v1 = 1'b1; f_rsp_ready = 1'b0;

        // ---- reset with both requesters valid ----
        tick(); tick();
        #1;
        chk("rst_req0_ready", 64'(rr[0]), 64'd0);
        chk("rst_req1_ready", 64'(rr[1]), 64'd0);
        chk("rst_alu_execute", 64'(alu_execute), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_result", 64'(rsp_result), 64'd0);
        chk("rst_rsp_id_flags", 64'({rsp_id, rsp_zero, rsp_negative, rsp_overflow}), 64'd0);
        chk("rst_fp_ready", 64'({f_r0, f_r1}), 64'd0);
        tick();
        rv[0] = 1'b0; rv[1] = 1'b0; f_v0 = 1'b0; f_v1 = 1'b0;
        resetn = 1'b1;

        // ---- latency: req0 add 12+13 ----
        lat_test(0, 32'd12, 32'd13, 3'b000, 1'b0, {1'b0, 3'b000, 32'h19});
        drain();

        // ---- contention after reset: req0 first, then req1 ----
        do_reset();
        rv[0] = 1'b1; ra[0] = 32'd12; rb[0] = 32'd13; rf[0] = 3'b000; rs[0] = 1'b0;
        rv[1] = 1'b1; ra[1] = 32'd11; rb[1] = 32'd13; rf[1] = 3'b000; rs[1] = 1'b1;
        #1;
        chk("cont_req0_first", 64'({rr[0], rr[1]}), 64'b10);
        exp_q.push_back({1'b0, 3'b000, 32'h19});
        tick();
        rv[0] = 1'b0;
        #1;
        chk("cont_exec_no_ready", 64'(rr[1]), 64'd0);
        tick();
        #1;
        chk("cont_req1_next", 64'({rr[0], rr[1]}), 64'b01);
        exp_q.push_back({1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE});
        tick();
        rv[1] = 1'b0;
        drain();

        // ---- table-driven vectors, alternating requesters ----
        for (int i = 0; i < 11; i++) begin
            issue(i % 2, vt[i].a, vt[i].b, vt[i].f3, vt[i].s, 1'b1,
                  {1'(i % 2), vt[i].z, vt[i].n, vt[i].v, vt[i].r});
            tick();
            rv[i % 2] = 1'b0;
        end
        drain();

        // ---- consumer stall with req1 pending ----
        do_reset();
        rsp_ready = 1'b0;
        rv[0] = 1'b1; ra[0] = 32'd12; rb[0] = 32'd13; rf[0] = 3'b000; rs[0] = 1'b0;
        rv[1] = 1'b1; ra[1] = 32'd11; rb[1] = 32'd13; rf[1] = 3'b000; rs[1] = 1'b1;
        #1;
        chk("stall_grant0", 64'({rr[0], rr[1]}), 64'b10);
        exp_q.push_back({1'b0, 3'b000, 32'h19});
        tick();
        rv[0] = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("stall_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("stall_rsp_stable", 64'({rsp_id, rsp_zero, rsp_negative, rsp_overflow, rsp_result}),
                64'({1'b0, 3'b000, 32'h19}));
            chk("stall_req1_ready", 64'(rr[1]), 64'd0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("stall_release_req1_ready", 64'(rr[1]), 64'd1);
        exp_q.push_back({1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE});
        tick();
        rv[1] = 1'b0;
        #1;
        chk("stall_release_exec", 64'(alu_execute), 64'd1);
        drain();

        // ---- reset during EXEC discards the operation ----
        issue(1, 32'd3, 32'd4, 3'b000, 1'b0, 1'b0, 36'd0);
        tick();
        rv[1] = 1'b0;
        #1;
        chk("rstx_exec_before", 64'(alu_execute), 64'd1);
        resetn = 1'b0;
        #1;
        chk("rstx_exec_gated", 64'(alu_execute), 64'd0);
        tick();
        resetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("rstx_no_rsp", 64'(rsp_valid), 64'd0);
            tick();
        end
        lat_test(1, 32'd11, 32'd13, 3'b000, 1'b1, {1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE});
        drain();

        // ---- fixed priority: both valid for 10 ops ----
        f_v0 = 1'b1; f_v1 = 1'b1; f_rsp_ready = 1'b1;
        fp_cnt = 0;
        fp_r1_seen = 1'b0;
        for (int k = 0; k < 40 && fp_cnt < 10; k++) begin
            #1;
            if (f_r1) fp_r1_seen = 1'b1;
            if (f_rsp_valid) begin
                fp_cnt++;
                chk("fp_rsp_id", 64'(f_rsp_id), 64'd0);
                chk("fp_rsp_result", 64'(f_rsp_result), 64'd3);
            end
            tick();
        end
        chk("fp_rsp_count", 64'(fp_cnt), 64'd10);
        chk("fp_req1_ready_seen", 64'(fp_r1_seen), 64'd0);
        f_v0 = 1'b0; f_v1 = 1'b0;
        tick(); tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 FIXED_PRIORITY, 0, 1 = requester 0 always wins contention; 0 = round-robin.
REQ-002 clk  in  1  rising-edge clock; the only clock.
REQ-003 resetn  in  1  synchronous, active-low reset.
REQ-004 reqK_valid  in  1  requester K (K=0,1) presents an operation.
REQ-005 reqK_ready  out  1  operation of requester K accepted this cycle.
REQ-006 reqK_op_a, reqK_op_b  in  32  operands of requester K.
REQ-007 reqK_funct3  in  3  RV32I funct3 of requester K.
REQ-008 reqK_op_sign  in  1  sub/sra select of requester K.
REQ-009 alu_execute  out  1  enable to shared combinational ALU.
REQ-010 alu_op_a, alu_op_b  out  32  operands to ALU.
REQ-011 alu_funct3  out  3  funct3 to ALU.
REQ-012 alu_op_sign  out  1  op_sign to ALU.
REQ-013 alu_result  in  32  ALU result.
REQ-014 alu_zero, alu_negative, alu_overflow  in  1 each  ALU flags.
REQ-015 rsp_valid  out  1  response available.
REQ-016 rsp_ready  in  1  consumer takes response.
REQ-017 rsp_id  out  1  requester index owning the response.
REQ-018 rsp_result  out  32  registered result.
REQ-019 rsp_zero, rsp_negative, rsp_overflow  out  1 each  registered flags.

Function
REQ-020 FSM states IDLE, EXEC, RESP; the block SHALL hold exactly one operation in flight.
REQ-021 IDLE: any reqK_valid -> grant one, assert its reqK_ready combinationally that cycle, capture op_a/op_b/funct3/op_sign and id into registers, next EXEC.
REQ-022 reqK_ready SHALL be high only for the granted requester, and only in IDLE or in RESP with rsp_ready high; never both readies high together.
REQ-023 EXEC: alu_execute=1, ALU buses driven from captured registers; at clock edge capture alu_result and flags into rsp_* registers, next RESP.
REQ-024 alu_execute SHALL be 0 in IDLE and RESP; alu_* buses SHALL hold last captured values outside EXEC.
REQ-025 RESP: rsp_valid=1; rsp_* stable while rsp_ready=0.
REQ-026 RESP with rsp_ready=1: if any reqK_valid, grant and capture it same cycle, next EXEC; else next IDLE.
REQ-027 Latency: accept at cycle N -> alu_execute at N+1 -> rsp_valid at N+2; peak throughput one op per 2 cycles.
REQ-028 Round-robin: last_grant register; single valid -> that requester; both valid -> requester != last_grant; last_grant updated on every grant.
REQ-029 FIXED_PRIORITY=1: both valid -> requester 0; last_grant ignored.
REQ-030 Request withdrawn (valid drops) before ready SHALL be ignored; no capture.
REQ-031 Block SHALL not modify operands or results; width and flag semantics are those of the ALU.

Reset
REQ-032 resetn=0 at a rising edge -> state IDLE, last_grant=1, rsp_valid=0, rsp_id=0, rsp_result=0, rsp flags 0, captured operands/funct3/op_sign 0.
REQ-033 While resetn=0: reqK_ready=0, alu_execute=0.
REQ-034 Reset in EXEC or RESP SHALL discard the operation; no response produced.

Verification
REQ-035 resetn low 2 cycles with both reqK_valid high -> both ready 0, alu_execute 0, rsp_valid 0, rsp_result 0.
REQ-036 req0 add 12+13 (funct3 000, sign 0) at N, rsp_ready high -> req0_ready N, alu_execute N+1, rsp_valid N+2, rsp_result 0x19, rsp_id 0, flags 000.
REQ-037 After reset, req0 add 12+13 and req1 sub 11-13 both valid -> req0 granted first; then req1: rsp_result 0xFFFFFFFE, rsp_id 1, negative 1, zero 0.
REQ-038 rsp_ready held low 5 cycles in RESP with req1 pending -> rsp_* stable, req1_ready 0; rsp_ready high -> req1_ready same cycle, alu_execute next cycle.
REQ-039 resetn pulsed low during EXEC -> rsp_valid never asserts for that op; next accepted op responds normally at N+2.
REQ-040 FIXED_PRIORITY=1, both valid continuously 10 ops -> every rsp_id 0, req1_ready never high.
